// File: rtl/fmin_reduce.sv
// fmin_reduce: streaming FP32 minimum reducer with RISC-V FMIN.S semantics.
// Reduces one valid/ready packet to its minimum, sticky sNaN flag and element count.
// Optional feature macro: FMIN_REDUCE_ARGMIN_EN adds the m_idx argmin output.
module fmin_reduce #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_nv,
  output logic [CNT_W-1:0] m_count
`ifdef FMIN_REDUCE_ARGMIN_EN
  ,
  output logic [CNT_W-1:0] m_idx
`endif
);

  localparam logic [WIDTH-1:0] CANON_NAN = WIDTH'(32'h7FC0_0000);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             nv_q, nv_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef FMIN_REDUCE_ARGMIN_EN
  logic [CNT_W-1:0] idx_q, idx_d;
`endif
  logic             accept;
  logic             replace;
  logic             load_out;

  function automatic logic is_nan(input logic [WIDTH-1:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  function automatic logic is_snan(input logic [WIDTH-1:0] v);
    return is_nan(v) && !v[22];
  endfunction

  // True when x is strictly below acc (ties and NaN x keep acc; a NaN acc yields to any non-NaN)
  function automatic logic takes_x(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] x);
    logic res;
    res = 1'b0;
    if (is_nan(x))           res = 1'b0;
    else if (is_nan(a))      res = 1'b1;
    else if (a[31] != x[31]) res = x[31];
    else if (!x[31])         res = (x[30:0] < a[30:0]);
    else                     res = (x[30:0] > a[30:0]);
    return res;
  endfunction

  assign accept   = s_valid & s_ready;
  assign replace  = takes_x(acc_q, s_data);
  assign load_out = (state_q != OUT) && (state_d == OUT);

  // Next-state and accumulator update
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    nv_d    = nv_q;
    cnt_d   = cnt_q;
`ifdef FMIN_REDUCE_ARGMIN_EN
    idx_d   = idx_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = s_data;
          nv_d    = is_snan(s_data);
          cnt_d   = CNT_W'(1);
`ifdef FMIN_REDUCE_ARGMIN_EN
          idx_d   = '0;
`endif
          state_d = s_last ? OUT : ACC;
        end
      end
      ACC: begin
        if (accept) begin
          if (replace) acc_d = s_data;
`ifdef FMIN_REDUCE_ARGMIN_EN
          if (replace && (cnt_q != CNT_MAX)) idx_d = cnt_q;
`endif
          nv_d  = nv_q | is_snan(s_data);
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
          if (s_last) state_d = OUT;
        end
      end
      OUT: begin
        if (m_valid && m_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, accumulator and registered output ports
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      nv_q    <= 1'b0;
      cnt_q   <= '0;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_nv    <= 1'b0;
      m_count <= '0;
`ifdef FMIN_REDUCE_ARGMIN_EN
      idx_q   <= '0;
      m_idx   <= '0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      nv_q    <= nv_d;
      cnt_q   <= cnt_d;
      s_ready <= (state_d != OUT);
      m_valid <= (state_d == OUT);
`ifdef FMIN_REDUCE_ARGMIN_EN
      idx_q   <= idx_d;
`endif
      if (load_out) begin
        m_data  <= is_nan(acc_d) ? CANON_NAN : acc_d;
        m_nv    <= nv_d;
        m_count <= cnt_d;
`ifdef FMIN_REDUCE_ARGMIN_EN
        m_idx   <= idx_d;
`endif
      end
    end
  end

endmodule
